// File: rtl/bcd_tick_counter_pkg.sv
// Shared constants for the BCD tick counter
// and the seven-segment display driver.
package bcd_tick_counter_pkg;

    localparam int DIGITS = 4;
    localparam int BCD_W = 16;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 16'h0000;
    localparam logic [BCD_W-1:0] BCD_NINES = 16'h9999;

    function automatic logic [3:0] bcd_clamp(
        input logic [3:0] d
    );
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_tick_counter_if.sv
// Control and count bundle between the tick
// counter and its host / display driver.
interface bcd_tick_counter_if;
    import bcd_tick_counter_pkg::*;

    logic             run;
    logic             up;
    logic             clear_;
    logic             load;
    logic [BCD_W-1:0] load_bcd;
    logic [BCD_W-1:0] count_bcd;
    logic             wrap;
    logic             update;

    modport master (
        output run, up, clear_, load, load_bcd,
        input  count_bcd, wrap, update
    );

    modport slave (
        input  run, up, clear_, load, load_bcd,
        output count_bcd, wrap, update
    );

endinterface

// File: rtl/bcd_digit.sv
// One decade: next value for inc/dec with
// carry/borrow ripple, plus a clamped load value.
module bcd_digit
    import bcd_tick_counter_pkg::*;
(
    input  logic [3:0] i_cur,
    input  logic       i_up,
    input  logic       i_cin,
    input  logic [3:0] i_load,
    output logic [3:0] o_next,
    output logic       o_cout,
    output logic [3:0] o_load
);

    always_comb begin
        o_next = i_cur;
        o_cout = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_cur >= BCD_MAX) begin
                    o_next = 4'd0;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_cur + 4'd1;
                end
            end else begin
                if (i_cur == 4'd0) begin
                    o_next = BCD_MAX;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_cur - 4'd1;
                end
            end
        end
    end

    assign o_load = bcd_clamp(i_load);

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled 4-digit packed-BCD up/down counter
// with load, clear, wrap and update pulses.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter int PRESCALE = 3200000
) (
    input  logic           clk,
    input  logic           reset_,
    bcd_tick_counter_if.slave bus
);

    localparam int PRESCALE_W = $clog2(PRESCALE);
    localparam logic [PRESCALE_W-1:0] PRE_LAST =
        PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_pre;
    logic [BCD_W-1:0]      r_count;
    logic                  r_wrap;
    logic                  r_update;

    logic                  w_tick;
    logic [DIGITS:0]       w_carry;
    logic [BCD_W-1:0]      w_step;
    logic [BCD_W-1:0]      w_load;

    assign w_tick = bus.run && (r_pre == PRE_LAST);
    assign w_carry[0] = 1'b1;

    // Ripple chain: digit 0 always steps, higher
    // digits step only on carry/borrow.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .i_cur  (r_count[4*g +: 4]),
            .i_up   (bus.up),
            .i_cin  (w_carry[g]),
            .i_load (bus.load_bcd[4*g +: 4]),
            .o_next (w_step[4*g +: 4]),
            .o_cout (w_carry[g+1]),
            .o_load (w_load[4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_pre    <= '0;
            r_count  <= BCD_ZERO;
            r_wrap   <= 1'b0;
            r_update <= 1'b0;
        end else if (!bus.clear_) begin
            r_pre    <= '0;
            r_count  <= BCD_ZERO;
            r_wrap   <= 1'b0;
            r_update <= 1'b1;
        end else if (bus.load) begin
            r_pre    <= '0;
            r_count  <= w_load;
            r_wrap   <= 1'b0;
            r_update <= 1'b1;
        end else begin
            if (bus.run) begin
                r_pre <= w_tick ? '0 : r_pre + PRESCALE_W'(1);
            end
            if (w_tick) begin
                r_count  <= w_step;
                r_wrap   <= w_carry[DIGITS];
                r_update <= 1'b1;
            end else begin
                r_wrap   <= 1'b0;
                r_update <= 1'b0;
            end
        end
    end

    assign bus.count_bcd = r_count;
    assign bus.wrap      = r_wrap;
    assign bus.update    = r_update;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter
// with PRESCALE=4 and directed vectors.
module tb_bcd_tick_counter;

    localparam int P = 4;

    logic clk = 1'b0;
    logic reset_ = 1'b0;

    bcd_tick_counter_if bus ();

    bcd_tick_counter #(.PRESCALE(P)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [16:0] m_q[$];
    int m_val = 0;
    bit m_up = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10),
                4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Monitor: every update must match the oldest
    // expectation; wrap must never appear alone.
    always @(negedge clk) begin
        if (reset_) begin
            if (bus.update) begin
                if (m_q.size() == 0) begin
                    chk("unexpected_update", {15'd0, bus.update}, 0);
                end else begin
                    logic [16:0] e;
                    e = m_q.pop_front();
                    chk("sb_count", int'(bus.count_bcd), int'(e[15:0]));
                    chk("sb_wrap", int'(bus.wrap), int'(e[16]));
                end
            end else begin
                chk("idle_wrap", int'(bus.wrap), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_step();
        int nv;
        bit w;
        if (m_up) begin
            nv = (m_val + 1) % 10000;
            w = (m_val == 9999);
        end else begin
            nv = (m_val + 9999) % 10000;
            w = (m_val == 0);
        end
        m_val = nv;
        m_q.push_back({w, to_bcd(nv)});
    endtask

    task automatic do_steps(input int n);
        for (int k = 0; k < n; k++) begin
            push_step();
            tick(P);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input int dec);
        m_q.push_back({1'b0, to_bcd(dec)});
        bus.load = 1'b1;
        bus.load_bcd = v;
        tick(1);
        bus.load = 1'b0;
        m_val = dec;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.up = 1'b1;
        bus.clear_ = 1'b1;
        bus.load = 1'b0;
        bus.load_bcd = 16'h0000;
        tick(3);
        chk("rst_count", int'(bus.count_bcd), 0);
        chk("rst_wrap", int'(bus.wrap), 0);
        chk("rst_update", int'(bus.update), 0);

        // First step after PRESCALE edges, then to 0010.
        reset_ = 1'b1;
        bus.run = 1'b1;
        push_step();
        tick(3);
        chk("pre_first", int'(bus.count_bcd), 0);
        tick(1);
        chk("first_step", int'(bus.count_bcd), 16'h0001);
        chk("upd_pulse", int'(bus.update), 1);
        tick(1);
        chk("upd_one", int'(bus.update), 0);
        for (int k = 0; k < 9; k++) push_step();
        tick(35);
        chk("ten", int'(bus.count_bcd), 16'h0010);

        // Up wrap.
        do_load(16'h9998, 9998);
        do_steps(3);
        chk("after_wrap_up", int'(bus.count_bcd), 16'h0001);

        // Down wrap.
        bus.up = 1'b0;
        m_up = 1'b0;
        do_load(16'h0000, 0);
        do_steps(2);
        chk("after_wrap_dn", int'(bus.count_bcd), 16'h9998);

        // Pause mid-period keeps the phase.
        tick(2);
        bus.run = 1'b0;
        tick(10);
        chk("frozen", int'(bus.count_bcd), 16'h9998);
        chk("frozen_upd", int'(bus.update), 0);
        bus.run = 1'b1;
        push_step();
        tick(1);
        chk("resume_1", int'(bus.count_bcd), 16'h9998);
        tick(1);
        chk("resume_2", int'(bus.count_bcd), 16'h9997);

        // Sanitised load zeroes the prescaler.
        do_load(16'h1A3F, 1939);
        chk("sanitise", int'(bus.count_bcd), 16'h1939);
        bus.up = 1'b1;
        m_up = 1'b1;
        push_step();
        tick(3);
        chk("load_phase", int'(bus.count_bcd), 16'h1939);
        tick(1);
        chk("load_step", int'(bus.count_bcd), 16'h1940);

        // Clear + load on a tick edge: clear wins, no step.
        tick(3);
        m_q.push_back({1'b0, 16'h0000});
        bus.clear_ = 1'b0;
        bus.load = 1'b1;
        bus.load_bcd = 16'h1234;
        tick(1);
        bus.clear_ = 1'b1;
        bus.load = 1'b0;
        m_val = 0;
        chk("clr_count", int'(bus.count_bcd), 0);
        chk("clr_wrap", int'(bus.wrap), 0);
        push_step();
        tick(3);
        chk("clr_phase", int'(bus.count_bcd), 0);
        tick(1);
        chk("clr_step", int'(bus.count_bcd), 16'h0001);

        // Asynchronous reset mid-period.
        do_load(16'h0057, 57);
        tick(2);
        chk("pre_async", int'(bus.count_bcd), 16'h0057);
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_count", int'(bus.count_bcd), 0);
        chk("async_wrap", int'(bus.wrap), 0);
        chk("async_update", int'(bus.update), 0);
        tick(2);
        chk("sb_drained", m_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
